vfu_mask_steer: RTL
===================

Name: vfu_mask_steer

Overview:
- Routes the lane's single mask-unit broadcast (mask strobe plus valid/ready) to exactly one functional unit, ALU or MFPU, in the order masked instructions were issued to them.
- Removes the hazard where concurrent masked ALU and MFPU instructions both accept the same mask word.
- Sits in the lane between the mask unit, the lane sequencer and the vector FU stage. It replaces the OR of the per-FU mask ready signals.

Parameters:
- StrbWidth, 8, width of the mask strobe word (ELEN/8).
- Depth, 4, masked-instruction queue entries; power of two, ≥2.
- CntWidth, 16, width of the per-instruction mask-word count.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- op_valid_i  in  1  sequencer issues a masked vinsn to a FU
- op_fu_i  in  1  target FU: 0=ALU, 1=MFPU
- op_words_i  in  CntWidth  number of mask words the vinsn consumes in this lane
- op_ready_o  out  1  queue can accept an entry
- mask_i  in  StrbWidth  mask word from mask unit
- mask_valid_i  in  1  mask word valid
- mask_ready_o  out  1  mask word consumed
- alu_mask_o  out  StrbWidth  mask word to ALU
- alu_mask_valid_o  out  1  valid to ALU
- alu_mask_ready_i  in  1  ALU accepts
- mfpu_mask_o  out  StrbWidth  mask word to MFPU
- mfpu_mask_valid_o  out  1  valid to MFPU
- mfpu_mask_ready_i  in  1  MFPU accepts
- busy_o  out  1  at least one queued entry
- pending_o  out  $clog2(Depth)+1  number of queued entries

Behaviour:
- Queue
  - Circular FIFO of {fu, words}, Depth entries, with read pointer, write pointer and count.
  - Head entry plus consumed-word counter cnt_q (CntWidth).
- Enqueue
  - Push when op_valid_i & op_ready_o & op_words_i≠0.
  - op_ready_o = (count≠Depth). When full, a push is refused even if a pop happens in the same cycle.
  - op_words_i=0: handshake completes (op_ready_o as usual), nothing is stored.
- Steering (combinational, zero latency)
  - alu_mask_o and mfpu_mask_o = mask_i, always.
  - head_alu = busy & head.fu==0; head_mfpu = busy & head.fu==1.
  - alu_mask_valid_o = mask_valid_i & head_alu.
  - mfpu_mask_valid_o = mask_valid_i & head_mfpu.
  - mask_ready_o = (head_alu & alu_mask_ready_i) | (head_mfpu & mfpu_mask_ready_i).
  - Queue empty: both valids 0 and mask_ready_o 0. The mask word stalls at the mask unit and is never dropped.
  - The non-head FU never sees valid, whatever its ready.
- Consumption
  - hs = mask_valid_i & mask_ready_o.
  - On hs: if cnt_q == head.words−1, pop the head and set cnt_q←0; else cnt_q←cnt_q+1.
- Pointers and count
  - Pointers wrap modulo Depth.
  - Count updates by +1 (push only), −1 (pop only), unchanged (push and pop in the same cycle, allowed when not full).
  - Empty queue: a push becomes the head next cycle. No same-cycle bypass.
- busy_o = (count≠0); pending_o = count.
- Reset
  - Synchronous: on rising clk with rst_ni=0, clear pointers, count and cnt_q.
  - Outputs after reset: op_ready_o=1, busy_o=0, pending_o=0, all valids 0, mask_ready_o=0.
  - Reset mid-instruction discards all entries and partial counts. No mask word is forwarded in that cycle.
- Ordering invariant: the i-th mask handshake after the push of entry k goes to entry k's FU, only once entries 0..k−1 have received all their words.
- Out-of-range input: op_fu_i is 1 bit, so none exists.

Test Plan:
- Reset, then idle: op_ready_o=1, busy_o=0, pending_o=0, both valids 0. Drive mask_valid_i=1: mask_ready_o stays 0 for 10 cycles.
- Push {ALU,3}; drive mask_i=8'hA5 valid with alu ready=1 → 3 handshakes on ALU, mfpu_mask_valid_o=0 throughout. Pop after the 3rd; busy_o=0.
- Push {ALU,2} then {MFPU,2}; both FUs ready, mask valid 4 cycles → words 1–2 go to ALU and 3–4 to MFPU, with no overlap.
- Head MFPU with mfpu ready=0 and alu ready=1 → mask_ready_o=0 and alu_mask_valid_o=0; cnt_q unchanged.
- Fill: push 4 entries of {ALU,1}, so op_ready_o=0. Push attempt with a simultaneous pop → refused, pending_o=3 next cycle. Push in the following cycle succeeds, and the write pointer wraps.
- Push op_words_i=0 → pending_o stays 0. Push {MFPU,5}, consume 2, pulse rst_ni=0 → pending_o=0, valids 0. Re-push {ALU,1} → its first word goes to ALU.

Source files
------------

// File: rtl/vfu_mask_steer.sv
// Steers the lane's single mask-unit broadcast to ALU or MFPU in the
// order masked vector instructions were issued to those units.
module vfu_mask_steer #(
    parameter int unsigned StrbWidth = 8,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       op_valid_i,
    input  logic                       op_fu_i,
    input  logic [CntWidth-1:0]        op_words_i,
    output logic                       op_ready_o,
    input  logic [StrbWidth-1:0]       mask_i,
    input  logic                       mask_valid_i,
    output logic                       mask_ready_o,
    output logic [StrbWidth-1:0]       alu_mask_o,
    output logic                       alu_mask_valid_o,
    input  logic                       alu_mask_ready_i,
    output logic [StrbWidth-1:0]       mfpu_mask_o,
    output logic                       mfpu_mask_valid_o,
    input  logic                       mfpu_mask_ready_i,
    output logic                       busy_o,
    output logic [$clog2(Depth):0]     pending_o
);

    localparam int unsigned PtrWidth   = $clog2(Depth);
    localparam int unsigned CountWidth = PtrWidth + 1;

    logic                  fu_q    [Depth];
    logic [CntWidth-1:0]   words_q [Depth];
    logic [PtrWidth-1:0]   rptr_q, wptr_q;
    logic [CountWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0]   cnt_q;

    logic                  head_fu;
    logic [CntWidth-1:0]   head_words;
    logic                  live;
    logic                  head_alu, head_mfpu;
    logic                  hs, last_word, push, pop;

    // Head decode and steering; reset cycle suppresses any forwarding
    always_comb begin
        head_fu           = fu_q[rptr_q];
        head_words        = words_q[rptr_q];
        live              = (count_q != '0) && rst_ni;
        head_alu          = live && !head_fu;
        head_mfpu         = live && head_fu;
        alu_mask_o        = mask_i;
        mfpu_mask_o       = mask_i;
        alu_mask_valid_o  = mask_valid_i && head_alu;
        mfpu_mask_valid_o = mask_valid_i && head_mfpu;
        mask_ready_o      = (head_alu && alu_mask_ready_i) || (head_mfpu && mfpu_mask_ready_i);
        op_ready_o        = (count_q != CountWidth'(Depth));
        busy_o            = (count_q != '0);
        pending_o         = count_q;
        hs                = mask_valid_i && mask_ready_o;
        last_word         = (cnt_q == head_words - CntWidth'(1));
        push              = op_valid_i && op_ready_o && (op_words_i != '0);
        pop               = hs && last_word;
    end

    // Occupancy update: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry payload storage; stale contents are harmless once count is cleared
    always_ff @(posedge clk_i) begin
        if (push) begin
            fu_q[wptr_q]    <= op_fu_i;
            words_q[wptr_q] <= op_words_i;
        end
    end

    // Pointers, occupancy and head word counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wptr_q <= wptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrWidth'(1);
                cnt_q  <= '0;
            end else if (hs) begin
                cnt_q  <= cnt_q + CntWidth'(1);
            end
        end
    end

endmodule
